dqn_replay_sampler: RTL and testbench
=====================================

Name: dqn_replay_sampler

Overview:
- Read-side companion to dqn_replay_memory. On a start request it draws a mini-batch of BATCH_SIZE transitions from memory.
- Indices are uniform pseudo-random, generated by an LFSR.
- Read requests go out one at a time; each returned transition is forwarded to the training datapath over a valid/ready handshake.
- Sits between the replay memory and the DQN trainer.

Parameters:
- DATA_WIDTH, 32, width of the state and reward fields (FP32)
- ACTION_WIDTH, 2, width of the action field
- ADDR_WIDTH, 14, replay-memory index width (covers 10000 entries)
- BATCH_SIZE, 4, transitions per mini-batch (≥1)
- SEED, 16'hACE1, LFSR reset value (nonzero)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_start  in  1  request one mini-batch
- i_ready_for_train  in  1  memory holds enough data to train
- i_fill_count  in  ADDR_WIDTH  number of valid memory entries
- o_rd_en  out  1  one-cycle read strobe to memory
- o_rd_addr  out  ADDR_WIDTH  read index
- i_rd_valid  in  1  memory read data valid
- i_rd_current_state_0, i_rd_current_state_1, i_rd_reward, i_rd_next_state_0, i_rd_next_state_1  in  DATA_WIDTH each  read data
- i_rd_action  in  ACTION_WIDTH  read data
- i_rd_done  in  1  read data
- o_valid  out  1  sample available to the trainer
- i_ready  in  1  trainer accepts the sample
- o_current_state_0, o_current_state_1, o_reward, o_next_state_0, o_next_state_1  out  DATA_WIDTH each  sample fields
- o_action  out  ACTION_WIDTH  sample field
- o_done  out  1  sample field
- o_last  out  1  current sample is the final one of the batch
- o_busy  out  1  batch in progress (state ≠ IDLE)
- o_batch_done  out  1  one-cycle pulse after the last sample is accepted

Behaviour:
- Reset:
  - state = IDLE, lfsr = SEED, sample count = 0.
  - Every output is 0, including all data fields.
  - Reset has priority in every state and aborts any batch mid-operation. A read response still in flight after reset is ignored.
- LFSR:
  - 16-bit Galois, right-shifting. Each step: lsb = lfsr[0]; lfsr >>= 1; if lsb, lfsr ^= 16'hB400.
  - Advances only in the REQ cycle.
- Index calculation:
  - o_rd_addr = (lfsr × fill_latched)[ADDR_WIDTH+15:16], computed from lfsr before it advances.
  - The product is full width (16+ADDR_WIDTH bits), unsigned, so the index is always < fill_latched.
- FSM states: IDLE, REQ, WAIT, OUT, DONE.
- IDLE:
  - If i_start && i_ready_for_train && i_fill_count ≠ 0: latch fill_latched = i_fill_count, clear count, go to REQ.
  - Otherwise i_start is ignored.
- REQ:
  - o_rd_en = 1 for exactly one cycle, with o_rd_addr valid; LFSR steps; go to WAIT.
- WAIT:
  - On i_rd_valid: register all i_rd_* fields into the o_* fields.
  - Set o_last = (count == BATCH_SIZE-1); go to OUT.
  - There is no timeout. Only one read is outstanding at a time.
- OUT:
  - o_valid = 1; data and o_last stay stable until i_ready.
  - On i_ready: o_valid drops the next cycle and count increments.
  - If the accepted sample was last, go to DONE; otherwise go to REQ.
- DONE:
  - o_batch_done = 1 for one cycle, o_last cleared, go to IDLE.
- Minimum time per sample: REQ → WAIT → OUT is 3 cycles plus memory latency.
- Boundaries and simultaneous events:
  - i_rd_valid outside WAIT is ignored.
  - i_start while o_busy is ignored; it is not queued.
  - Changes to i_fill_count or i_ready_for_train mid-batch have no effect.
  - fill_latched = 1 forces every address to 0.
  - BATCH_SIZE = 1 asserts o_last on the only sample.
  - The LFSR is not reseeded between batches; the sequence continues.

Test Plan:
- Reset check: assert rst for 3 cycles while i_start=1 → all outputs 0, o_busy=0, no o_rd_en.
- Basic batch:
  - Setup: i_fill_count=16, ready=1, memory model with 2-cycle latency returning data = address, i_ready=1, 1-cycle i_start.
  - Required response: exactly 4 o_rd_en pulses with addresses 10, 14, 7, 3.
  - o_last high only on the 4th sample; o_batch_done one cycle later; o_busy falls.
- Backpressure: hold i_ready=0 for 5 cycles during OUT → o_valid and every field stay constant, no new o_rd_en; release → the sample is accepted once.
- Start gating:
  - i_start with i_ready_for_train=0, or with i_fill_count=0 → no read, o_busy stays 0.
  - i_start pulse mid-batch → no second batch follows.
- fill_count=1 → all 4 addresses are 0, and the batch completes normally.
- Reset mid-WAIT, then a stray i_rd_valid → outputs 0, state IDLE, stray data ignored; the next batch repeats addresses 10, 14, 7, 3.

Source files
------------

// File: rtl/dqn_replay_sampler.sv
// Mini-batch sampler for the DQN replay memory: draws LFSR-indexed
// transitions one read at a time and streams them to the trainer.
module dqn_replay_sampler #(
    parameter int          DATA_WIDTH   = 32,
    parameter int          ACTION_WIDTH = 2,
    parameter int          ADDR_WIDTH   = 14,
    parameter int          BATCH_SIZE   = 4,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic                    i_ready_for_train,
    input  logic [ADDR_WIDTH-1:0]   i_fill_count,
    output logic                    o_rd_en,
    output logic [ADDR_WIDTH-1:0]   o_rd_addr,
    input  logic                    i_rd_valid,
    input  logic [DATA_WIDTH-1:0]   i_rd_current_state_0,
    input  logic [DATA_WIDTH-1:0]   i_rd_current_state_1,
    input  logic [DATA_WIDTH-1:0]   i_rd_reward,
    input  logic [DATA_WIDTH-1:0]   i_rd_next_state_0,
    input  logic [DATA_WIDTH-1:0]   i_rd_next_state_1,
    input  logic [ACTION_WIDTH-1:0] i_rd_action,
    input  logic                    i_rd_done,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [DATA_WIDTH-1:0]   o_current_state_0,
    output logic [DATA_WIDTH-1:0]   o_current_state_1,
    output logic [DATA_WIDTH-1:0]   o_reward,
    output logic [DATA_WIDTH-1:0]   o_next_state_0,
    output logic [DATA_WIDTH-1:0]   o_next_state_1,
    output logic [ACTION_WIDTH-1:0] o_action,
    output logic                    o_done,
    output logic                    o_last,
    output logic                    o_busy,
    output logic                    o_batch_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    localparam int CW = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(BATCH_SIZE - 1);
    localparam int SW = 5 * DATA_WIDTH + ACTION_WIDTH + 1;
    localparam int PW = ADDR_WIDTH + 16;

    state_t              state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [ADDR_WIDTH-1:0] fill_q, fill_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                last_q, last_d;
    logic [SW-1:0]       smp_q, smp_d;

    logic [PW-1:0] prod;
    logic [15:0]   lfsr_next;
    logic          unused_lo;

    // Scaling the 16-bit LFSR by fill keeps the index strictly below fill.
    assign prod      = {{ADDR_WIDTH{1'b0}}, lfsr_q} * {16'h0000, fill_q};
    assign unused_lo = ^prod[15:0];
    assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

    assign {o_current_state_0, o_current_state_1, o_reward,
            o_next_state_0, o_next_state_1, o_action, o_done} = smp_q;
    assign o_last = last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED;
            fill_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            smp_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            smp_q   <= smp_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        fill_d       = fill_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        smp_d        = smp_q;
        o_rd_en      = 1'b0;
        o_rd_addr    = '0;
        o_valid      = 1'b0;
        o_batch_done = 1'b0;
        o_busy       = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                if (i_start && i_ready_for_train && (i_fill_count != '0)) begin
                    fill_d  = i_fill_count;
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                o_rd_en   = 1'b1;
                o_rd_addr = prod[PW-1:16];
                lfsr_d    = lfsr_next;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (i_rd_valid) begin
                    smp_d = {i_rd_current_state_0, i_rd_current_state_1,
                             i_rd_reward, i_rd_next_state_0,
                             i_rd_next_state_1, i_rd_action, i_rd_done};
                    last_d  = (cnt_q == LAST_IDX);
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = last_q ? S_DONE : S_REQ;
                end
            end
            S_DONE: begin
                o_batch_done = 1'b1;
                last_d       = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dqn_replay_sampler.sv
// Randomized bench for dqn_replay_sampler with a latency-programmable
// memory model and an arithmetic LFSR/index reference.
module tb_dqn_replay_sampler;

    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b1;
    logic        i_ready_for_train = 1'b1;
    logic [13:0] i_fill_count = 14'd16;
    logic        o_rd_en;
    logic [13:0] o_rd_addr;
    logic        i_rd_valid = 1'b0;
    logic [31:0] i_rd_current_state_0 = '0;
    logic [31:0] i_rd_current_state_1 = '0;
    logic [31:0] i_rd_reward = '0;
    logic [31:0] i_rd_next_state_0 = '0;
    logic [31:0] i_rd_next_state_1 = '0;
    logic [1:0]  i_rd_action = '0;
    logic        i_rd_done = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_current_state_0, o_current_state_1, o_reward;
    logic [31:0] o_next_state_0, o_next_state_1;
    logic [1:0]  o_action;
    logic        o_done, o_last, o_busy, o_batch_done;

    dqn_replay_sampler dut (
        .clk(clk), .rst(rst),
        .i_start(i_start), .i_ready_for_train(i_ready_for_train),
        .i_fill_count(i_fill_count),
        .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
        .i_rd_valid(i_rd_valid),
        .i_rd_current_state_0(i_rd_current_state_0),
        .i_rd_current_state_1(i_rd_current_state_1),
        .i_rd_reward(i_rd_reward),
        .i_rd_next_state_0(i_rd_next_state_0),
        .i_rd_next_state_1(i_rd_next_state_1),
        .i_rd_action(i_rd_action), .i_rd_done(i_rd_done),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_current_state_0(o_current_state_0),
        .o_current_state_1(o_current_state_1),
        .o_reward(o_reward),
        .o_next_state_0(o_next_state_0),
        .o_next_state_1(o_next_state_1),
        .o_action(o_action), .o_done(o_done), .o_last(o_last),
        .o_busy(o_busy), .o_batch_done(o_batch_done)
    );

    always #5 clk = ~clk;

    logic [163:0] smp_o;
    logic [181:0] all_o;
    assign smp_o = {o_current_state_0, o_current_state_1, o_reward,
                    o_next_state_0, o_next_state_1, o_action, o_done, o_last};
    assign all_o = {o_rd_en, o_rd_addr, o_valid, smp_o, o_busy, o_batch_done};

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] mem_salt = 32'h1234_5678;
    int          mem_lat = 2;
    int          mem_cnt = 0;
    logic [13:0] mem_addr = '0;
    logic [15:0] m_lfsr = 16'hACE1;
    int          basic_exp[4] = '{10, 14, 7, 3};

    int           got_addr[$];
    logic [163:0] got_smp[$];
    int           done_cnt, done_cyc, last_acc_cyc;
    bit           timed_out;
    logic         busy_after;

    function automatic logic [31:0] mem_word(input logic [13:0] a, input int k);
        return (32'(a) * 32'h9E37_79B1) ^ (mem_salt + 32'(k * 32'h0101_0101));
    endfunction

    function automatic logic [163:0] exp_smp(input int a, input logic last);
        logic [13:0] aa;
        aa = 14'(a);
        return {mem_word(aa, 0), mem_word(aa, 1), mem_word(aa, 2),
                mem_word(aa, 3), mem_word(aa, 4),
                aa[1:0] ^ mem_salt[1:0], aa[0] ^ mem_salt[7], last};
    endfunction

    // Reference index: scale LFSR by fill, then take one Galois step.
    function automatic int model_next(input int fill);
        int a;
        a = int'((longint'(m_lfsr) * longint'(fill)) >> 16);
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        return a;
    endfunction

    // Memory: answers each read strobe after mem_lat cycles, junk otherwise.
    always @(negedge clk) begin
        i_rd_valid <= 1'b0;
        i_rd_current_state_0 <= $urandom;
        i_rd_current_state_1 <= $urandom;
        i_rd_reward <= $urandom;
        i_rd_next_state_0 <= $urandom;
        i_rd_next_state_1 <= $urandom;
        i_rd_action <= 2'($urandom);
        i_rd_done <= 1'($urandom);
        if (mem_cnt == 1) begin
            i_rd_valid <= 1'b1;
            i_rd_current_state_0 <= mem_word(mem_addr, 0);
            i_rd_current_state_1 <= mem_word(mem_addr, 1);
            i_rd_reward <= mem_word(mem_addr, 2);
            i_rd_next_state_0 <= mem_word(mem_addr, 3);
            i_rd_next_state_1 <= mem_word(mem_addr, 4);
            i_rd_action <= mem_addr[1:0] ^ mem_salt[1:0];
            i_rd_done <= mem_addr[0] ^ mem_salt[7];
        end
        if (mem_cnt != 0) mem_cnt <= mem_cnt - 1;
        if (o_rd_en) begin
            mem_addr <= o_rd_addr;
            mem_cnt <= mem_lat;
        end
    end

    task automatic run_batch(input bit do_start, input int fill,
                             input int rdy_pct, input bit poke);
        bit fin;
        fin = 0;
        got_addr.delete();
        got_smp.delete();
        done_cnt = 0;
        done_cyc = -1;
        last_acc_cyc = -1;
        timed_out = 0;
        busy_after = 1'bx;
        if (do_start) begin
            @(negedge clk);
            i_fill_count = 14'(fill);
            i_ready_for_train = 1'b1;
            i_start = 1'b1;
        end
        for (int c = 0; c < 3000 && !fin; c++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (poke && c == 5) begin
                i_start = 1'b1;
                i_fill_count = 14'($urandom);
                i_ready_for_train = 1'b0;
            end
            i_ready = (int'($urandom_range(99)) < rdy_pct);
            if (o_rd_en) got_addr.push_back(int'(o_rd_addr));
            if (o_valid && i_ready) begin
                got_smp.push_back(smp_o);
                last_acc_cyc = c;
            end
            if (o_batch_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c == done_cyc + 1) busy_after = o_busy;
            if (done_cyc >= 0 && c == done_cyc + 2) fin = 1;
        end
        if (done_cyc < 0) timed_out = 1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (all_o !== '0) begin
                tests_failed++;
                $display("FAIL reset_outputs cyc%0d: got %h expected 0", i, all_o);
            end
        end
        rst = 1'b0;
        i_start = 1'b0;
        m_lfsr = 16'hACE1;
    endtask

    task automatic test_basic;
        int e;
        mem_lat = 2;
        mem_salt = $urandom;
        run_batch(1, 16, 100, 0);
        tests_run++;
        if (timed_out || got_addr.size() != NB) begin
            tests_failed++;
            $display("FAIL basic_reads: got %0d reads (timeout=%0d) expected %0d",
                     got_addr.size(), timed_out, NB);
        end
        for (int i = 0; i < NB; i++) begin
            e = model_next(16);
            tests_run++;
            if (i >= got_addr.size() || got_addr[i] != basic_exp[i]) begin
                tests_failed++;
                $display("FAIL basic_addr[%0d]: got %0d expected %0d", i,
                         (i < got_addr.size()) ? got_addr[i] : -1, basic_exp[i]);
            end
            tests_run++;
            if (i >= got_smp.size() || got_smp[i] !== exp_smp(e, i == NB - 1)) begin
                tests_failed++;
                $display("FAIL basic_sample[%0d]: got %h expected %h", i,
                         (i < got_smp.size()) ? got_smp[i] : 164'h0,
                         exp_smp(e, i == NB - 1));
            end
        end
        tests_run++;
        if (done_cnt != 1 || done_cyc != last_acc_cyc + 1 || busy_after !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_done: got pulses=%0d at %0d busy=%b expected 1 at %0d busy=0",
                     done_cnt, done_cyc, busy_after, last_acc_cyc + 1);
        end
    endtask

    task automatic test_backpressure;
        logic [163:0] snap;
        bit found;
        int e;
        found = 0;
        mem_lat = 1;
        mem_salt = $urandom;
        i_ready = 1'b0;
        @(negedge clk);
        i_fill_count = 14'd16;
        i_ready_for_train = 1'b1;
        i_start = 1'b1;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (o_valid) found = 1;
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL bp_valid_timeout: got no o_valid expected o_valid within 50 cycles");
            $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
            $fatal(1);
        end
        snap = smp_o;
        e = model_next(16);
        tests_run++;
        if (snap !== exp_smp(e, 1'b0)) begin
            tests_failed++;
            $display("FAIL bp_first_sample: got %h expected %h", snap, exp_smp(e, 1'b0));
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if ({o_valid, o_rd_en, smp_o} !== {1'b1, 1'b0, snap}) begin
                tests_failed++;
                $display("FAIL bp_hold cyc%0d: got v=%b rd=%b %h expected v=1 rd=0 %h",
                         i, o_valid, o_rd_en, smp_o, snap);
            end
        end
        i_ready = 1'b1;
        run_batch(0, 16, 100, 0);
        tests_run++;
        if (timed_out || got_addr.size() != NB - 1 || got_smp.size() != NB - 1) begin
            tests_failed++;
            $display("FAIL bp_remaining: got reads=%0d samples=%0d expected %0d each",
                     got_addr.size(), got_smp.size(), NB - 1);
        end
        for (int i = 0; i < NB - 1; i++) begin
            e = model_next(16);
            tests_run++;
            if (i >= got_smp.size() || i >= got_addr.size() || got_addr[i] != e ||
                got_smp[i] !== exp_smp(e, i == NB - 2)) begin
                tests_failed++;
                $display("FAIL bp_sample[%0d]: got addr %0d expected addr %0d", i,
                         (i < got_addr.size()) ? got_addr[i] : -1, e);
            end
        end
    endtask

    task automatic test_start_gating;
        int bad;
        int e;
        for (int k = 0; k < 2; k++) begin
            bad = 0;
            @(negedge clk);
            i_ready_for_train = (k == 1);
            i_fill_count = (k == 1) ? 14'd0 : 14'd16;
            i_start = 1'b1;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                i_start = 1'b0;
                if (o_busy !== 1'b0 || o_rd_en !== 1'b0) bad++;
            end
            tests_run++;
            if (bad != 0) begin
                tests_failed++;
                $display("FAIL gate_case%0d: got %0d busy/read cycles expected 0", k, bad);
            end
        end
        mem_lat = 2;
        mem_salt = $urandom;
        run_batch(1, 16, 70, 1);
        tests_run++;
        if (timed_out || got_addr.size() != NB || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL gate_poke_batch: got reads=%0d done=%0d expected %0d and 1",
                     got_addr.size(), done_cnt, NB);
        end
        bad = 0;
        for (int i = 0; i < NB; i++) begin
            e = model_next(16);
            if (i >= got_addr.size() || got_addr[i] != e) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL gate_poke_addr: got %0d wrong addresses expected 0", bad);
        end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (o_busy !== 1'b0 || o_rd_en !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL gate_no_second_batch: got %0d busy cycles expected 0", bad);
        end
    endtask

    task automatic test_fill_one;
        int bad;
        int e;
        mem_lat = int'($urandom_range(1, 4));
        mem_salt = $urandom;
        run_batch(1, 1, 60, 0);
        bad = 0;
        for (int i = 0; i < NB; i++) begin
            e = model_next(1);
            if (i >= got_addr.size() || got_addr[i] != 0) bad++;
            if (i >= got_smp.size() || got_smp[i] !== exp_smp(e, i == NB - 1)) bad++;
        end
        tests_run++;
        if (timed_out || bad != 0 || got_addr.size() != NB || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL fill_one: got %0d errors reads=%0d done=%0d expected 0 %0d 1",
                     bad, got_addr.size(), done_cnt, NB);
        end
    endtask

    task automatic test_random;
        int bad;
        int e;
        int fill;
        for (int b = 0; b < 6; b++) begin
            fill = int'($urandom_range(1, 10000));
            mem_lat = int'($urandom_range(1, 4));
            mem_salt = $urandom;
            run_batch(1, fill, int'($urandom_range(40, 100)), 0);
            bad = 0;
            for (int i = 0; i < NB; i++) begin
                e = model_next(fill);
                if (i >= got_addr.size() || got_addr[i] != e || e >= fill) bad++;
                if (i >= got_smp.size() || got_smp[i] !== exp_smp(e, i == NB - 1)) bad++;
            end
            tests_run++;
            if (timed_out || bad != 0 || got_smp.size() != NB ||
                done_cnt != 1 || done_cyc != last_acc_cyc + 1) begin
                tests_failed++;
                $display("FAIL random_batch%0d fill=%0d: got %0d errors samples=%0d done=%0d expected 0 %0d 1",
                         b, fill, bad, got_smp.size(), done_cnt, NB);
            end
        end
    endtask

    task automatic test_reset_mid_wait;
        bit found;
        int bad;
        found = 0;
        mem_lat = 4;
        mem_salt = $urandom;
        i_ready = 1'b1;
        @(negedge clk);
        i_fill_count = 14'd16;
        i_ready_for_train = 1'b1;
        i_start = 1'b1;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (o_rd_en) found = 1;
        end
        @(negedge clk);
        tests_run++;
        if (!found || o_busy !== 1'b1 || o_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midwait_setup: got read=%0d busy=%b valid=%b expected 1 1 0",
                     found, o_busy, o_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            if (all_o !== '0) bad++;
            @(negedge clk);
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL midwait_stray: got %0d nonzero-output cycles expected 0", bad);
        end
        m_lfsr = 16'hACE1;
        mem_lat = 2;
        run_batch(1, 16, 100, 0);
        bad = 0;
        for (int i = 0; i < NB; i++) begin
            if (i >= got_addr.size() || got_addr[i] != basic_exp[i]) bad++;
            void'(model_next(16));
        end
        tests_run++;
        if (timed_out || bad != 0 || got_addr.size() != NB) begin
            tests_failed++;
            $display("FAIL midwait_rerun: got %0d wrong of %0d reads expected 0 of %0d",
                     bad, got_addr.size(), NB);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_start_gating();
        test_fill_one();
        test_random();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
